// File: rtl/mem_req_scheduler_pkg.sv
// Shared state encoding and AXI constants for the L1 memory request scheduler.
package mem_req_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [2:0] SIZE_WORD     = 3'd2;
  localparam logic [3:0] ID_I          = 4'd0;
  localparam logic [3:0] ID_D          = 4'd1;

endpackage

// File: rtl/mem_req_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic prio_r;  // 1'b0: bit 0 wins a tie, 1'b1: bit 1 wins a tie

  // Grant decode from requests and tie-break pointer
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_r ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer moves past whichever side was just granted
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      prio_r <= 1'b0;
    end else if (upd && (gnt != 2'b00)) begin
      prio_r <= gnt[0];
    end
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// Shares one AXI master between I-cache refills, D-cache refills and D-cache
// write-throughs; one transaction outstanding, round-robin between I and D.
module mem_req_scheduler
  import mem_req_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [3:0]        REFILL_LEN = 4'd3,
  parameter logic [ADDR_W-1:0] UC_BASE    = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] UC_LIMIT   = 32'h1000_03FF
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_rreq,
  input  logic              d_wreq,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              i_rvalid,
  output logic              d_rvalid,
  output logic [31:0]       rdata,
  output logic              i_done,
  output logic              d_done,
  output logic              err,
  output logic [3:0]        ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [3:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [3:0]        RID,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [3:0]        AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [3:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [31:0]       WDATA,
  output logic [3:0]        WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [3:0]        BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);

  function automatic logic in_uc_window(input logic [ADDR_W-1:0] addr);
    return (addr >= UC_BASE) && (addr <= UC_LIMIT);
  endfunction

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic [3:0]        arlen_r;
  logic              sel_d_r;
  logic              rerr_r;
  logic [31:0]       rdata_r;
  logic              i_rvalid_r;
  logic              d_rvalid_r;
  logic              i_done_r;
  logic              d_done_r;
  logic              err_r;
  logic [1:0]        req_s;
  logic [1:0]        gnt_s;
  logic              idle_ok_s;
  logic              unused_s;

  assign req_s     = {d_rreq | d_wreq, i_req};
  // Requesters see done one cycle before they can drop req, so hold off a re-grant then
  assign idle_ok_s = (state_r == ST_IDLE) && !(i_done_r || d_done_r);
  assign unused_s  = ^{RID, BID};

  rr_arb2 u_arb (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .req     (req_s),
    .upd     (idle_ok_s),
    .gnt     (gnt_s)
  );

  // Transaction FSM, request latches and registered response signals
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_r    <= ST_IDLE;
      addr_r     <= '0;
      wdata_r    <= 32'h0;
      wstrb_r    <= 4'h0;
      arlen_r    <= 4'd0;
      sel_d_r    <= 1'b0;
      rerr_r     <= 1'b0;
      rdata_r    <= 32'h0;
      i_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      i_done_r   <= 1'b0;
      d_done_r   <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      i_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      i_done_r   <= 1'b0;
      d_done_r   <= 1'b0;
      err_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (idle_ok_s && (gnt_s != 2'b00)) begin
            rerr_r <= 1'b0;
            if (gnt_s[1]) begin
              sel_d_r <= 1'b1;
              addr_r  <= d_addr;
              wdata_r <= d_wdata;
              wstrb_r <= d_wstrb;
              arlen_r <= (d_rreq && in_uc_window(d_addr)) ? 4'd0 : REFILL_LEN;
              // Read wins when both D strobes are (illegally) high
              state_r <= d_rreq ? ST_AR : ST_AW;
            end else begin
              sel_d_r <= 1'b0;
              addr_r  <= i_addr;
              arlen_r <= REFILL_LEN;
              state_r <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (ARREADY) state_r <= ST_R;
        end
        ST_R: begin
          if (RVALID) begin
            rdata_r    <= RDATA;
            i_rvalid_r <= !sel_d_r;
            d_rvalid_r <= sel_d_r;
            if (RLAST) begin
              i_done_r <= !sel_d_r;
              d_done_r <= sel_d_r;
              err_r    <= rerr_r || (RRESP != AXI_RESP_OKAY);
              state_r  <= ST_IDLE;
            end else begin
              rerr_r <= rerr_r || (RRESP != AXI_RESP_OKAY);
            end
          end
        end
        ST_AW: begin
          if (AWREADY) state_r <= ST_W;
        end
        ST_W: begin
          if (WREADY) state_r <= ST_B;
        end
        ST_B: begin
          if (BVALID) begin
            d_done_r <= 1'b1;
            err_r    <= (BRESP != AXI_RESP_OKAY);
            state_r  <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Channel handshakes decoded from the registered state
  always_comb begin
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    WLAST   = 1'b0;
    BREADY  = 1'b0;
    case (state_r)
      ST_AR:   ARVALID = 1'b1;
      ST_R:    RREADY  = 1'b1;
      ST_AW:   AWVALID = 1'b1;
      ST_W: begin
        WVALID = 1'b1;
        WLAST  = 1'b1;
      end
      ST_B:    BREADY  = 1'b1;
      default: ARVALID = 1'b0;
    endcase
  end

  assign ARID     = sel_d_r ? ID_D : ID_I;
  assign ARADDR   = addr_r;
  assign ARLEN    = arlen_r;
  assign ARSIZE   = SIZE_WORD;
  assign ARBURST  = BURST_INCR;
  assign AWID     = ID_D;
  assign AWADDR   = addr_r;
  assign AWLEN    = 4'd0;
  assign AWSIZE   = SIZE_WORD;
  assign AWBURST  = BURST_INCR;
  assign WDATA    = wdata_r;
  assign WSTRB    = wstrb_r;
  assign rdata    = rdata_r;
  assign i_rvalid = i_rvalid_r;
  assign d_rvalid = d_rvalid_r;
  assign i_done   = i_done_r;
  assign d_done   = d_done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler: a transaction table driven through a
// simple AXI slave, plus hand sequences for arbitration and mid-burst reset.
module tb_mem_req_scheduler;
  import mem_req_pkg::*;

  localparam logic [1:0] K_I = 2'd0, K_DR = 2'd1, K_DW = 2'd2, K_DRW = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ar_delay;
    int          bad_beat;
    logic [1:0]  bresp;
    logic [3:0]  exp_len;
    logic [3:0]  exp_id;
    logic        exp_err;
  } vec_t;

  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic        i_req = 1'b0, d_rreq = 1'b0, d_wreq = 1'b0;
  logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
  logic [3:0]  d_wstrb = 4'h0;
  logic        i_rvalid, d_rvalid, i_done, d_done, err;
  logic [31:0] rdata;
  logic [3:0]  ARID, ARLEN, AWID, AWLEN;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST;
  logic        ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY;
  logic [3:0]  WSTRB;
  logic        ARREADY = 1'b0, AWREADY = 1'b0, WREADY = 1'b0;
  logic [3:0]  RID = 4'h0, BID = 4'h0;
  logic [31:0] RDATA = 32'h0;
  logic [1:0]  RRESP = 2'b00, BRESP = 2'b00;
  logic        RLAST = 1'b0, RVALID = 1'b0, BVALID = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tab[11];

  always #5 ACLK = ~ACLK;

  mem_req_scheduler dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .i_req(i_req), .i_addr(i_addr), .d_rreq(d_rreq), .d_wreq(d_wreq),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .rdata(rdata),
    .i_done(i_done), .d_done(d_done), .err(err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
    .BREADY(BREADY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Waits up to 16 cycles for ARVALID (or AWVALID); reports cycles taken.
  task automatic wait_addr(input bit want_aw, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      cyc++;
      if (want_aw ? AWVALID : ARVALID) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int          cyc;
    bit          ok;
    bit          is_d, is_wr;
    int          nb;
    logic [31:0] data;
    is_d   = (v.kind != K_I);
    is_wr  = (v.kind == K_DW);
    i_req  = (v.kind == K_I);
    d_rreq = (v.kind == K_DR) || (v.kind == K_DRW);
    d_wreq = (v.kind == K_DW) || (v.kind == K_DRW);
    i_addr = v.addr;
    d_addr = v.addr;
    d_wdata = v.wdata;
    d_wstrb = v.wstrb;
    wait_addr(is_wr, cyc, ok);
    chk({tag, " addr_valid_seen"}, {31'h0, ok}, 32'd1);
    if (ok) begin
      chk({tag, " grant_latency"}, cyc, 32'd1);
      if (!is_wr) begin
        chk({tag, " araddr"}, ARADDR, v.addr);
        chk({tag, " arlen"}, {28'h0, ARLEN}, {28'h0, v.exp_len});
        chk({tag, " arid"}, {28'h0, ARID}, {28'h0, v.exp_id});
        chk({tag, " arsize_burst"}, {27'h0, ARSIZE, ARBURST}, {27'h0, 3'd2, 2'b01});
        for (int k = 0; k < v.ar_delay; k++) begin
          step();
          chk({tag, " arvalid_hold"}, {31'h0, ARVALID}, 32'd1);
        end
        ARREADY = 1'b1;
        step();
        ARREADY = 1'b0;
        chk({tag, " ar_to_r"}, {30'h0, ARVALID, RREADY}, 32'd1);
        nb = int'(v.exp_len) + 1;
        for (int b = 0; b < nb; b++) begin
          data   = 32'hC0DE_0000 | v.addr[15:0] ^ b;
          RVALID = 1'b1;
          RDATA  = data;
          RLAST  = (b == nb - 1);
          RRESP  = (b == v.bad_beat) ? 2'b10 : 2'b00;
          step();
          chk({tag, " rvalid_side"}, {30'h0, i_rvalid, d_rvalid}, is_d ? 32'd1 : 32'd2);
          chk({tag, " rdata"}, rdata, data);
          if (b == nb - 1) begin
            chk({tag, " r_done"}, {30'h0, i_done, d_done}, is_d ? 32'd1 : 32'd2);
            chk({tag, " r_err"}, {31'h0, err}, {31'h0, v.exp_err});
          end else begin
            chk({tag, " no_early_done"}, {30'h0, i_done, d_done}, 32'd0);
          end
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
        RRESP  = 2'b00;
      end else begin
        chk({tag, " awaddr"}, AWADDR, v.addr);
        chk({tag, " awlen_id"}, {24'h0, AWLEN, AWID}, {24'h0, 4'd0, 4'd1});
        chk({tag, " awsize_burst"}, {27'h0, AWSIZE, AWBURST}, {27'h0, 3'd2, 2'b01});
        AWREADY = 1'b1;
        step();
        AWREADY = 1'b0;
        chk({tag, " w_phase"}, {29'h0, AWVALID, WVALID, WLAST}, 32'd3);
        chk({tag, " wdata"}, WDATA, v.wdata);
        chk({tag, " wstrb"}, {28'h0, WSTRB}, {28'h0, v.wstrb});
        WREADY = 1'b1;
        step();
        WREADY = 1'b0;
        chk({tag, " b_phase"}, {30'h0, WVALID, BREADY}, 32'd1);
        BVALID = 1'b1;
        BRESP  = v.bresp;
        step();
        BVALID = 1'b0;
        BRESP  = 2'b00;
        chk({tag, " b_done"}, {30'h0, i_done, d_done}, 32'd1);
        chk({tag, " b_err"}, {31'h0, err}, {31'h0, v.exp_err});
      end
    end
    i_req  = 1'b0;
    d_rreq = 1'b0;
    d_wreq = 1'b0;
    step();
    chk({tag, " done_is_pulse"}, {28'h0, i_done, d_done, err, BREADY | RREADY}, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int          cyc;
    bit          ok;
    logic [31:0] adata;

    //          kind   addr           wdata          wstrb   dly bad bresp  len   id    err
    tab[0]  = '{K_I,   32'h0000_1000, 32'h0,         4'h0,   2, -1, 2'b00, 4'd3, ID_I, 1'b0};
    tab[1]  = '{K_DR,  32'h1000_0004, 32'h0,         4'h0,   0, -1, 2'b00, 4'd0, ID_D, 1'b0};
    tab[2]  = '{K_DR,  32'h2000_0000, 32'h0,         4'h0,   1, -1, 2'b00, 4'd3, ID_D, 1'b0};
    tab[3]  = '{K_DW,  32'h3000_0010, 32'hDEAD_BEEF, 4'b0011, 0, -1, 2'b00, 4'd0, ID_D, 1'b0};
    tab[4]  = '{K_DW,  32'h3000_0020, 32'h0123_4567, 4'b1100, 0, -1, 2'b10, 4'd0, ID_D, 1'b1};
    tab[5]  = '{K_I,   32'h0000_2000, 32'h0,         4'h0,   0,  1, 2'b00, 4'd3, ID_I, 1'b1};
    tab[6]  = '{K_DR,  32'h1000_03FF, 32'h0,         4'h0,   0, -1, 2'b00, 4'd0, ID_D, 1'b0};
    tab[7]  = '{K_DR,  32'h1000_0400, 32'h0,         4'h0,   0, -1, 2'b00, 4'd3, ID_D, 1'b0};
    tab[8]  = '{K_DR,  32'h0FFF_FFFC, 32'h0,         4'h0,   0, -1, 2'b00, 4'd3, ID_D, 1'b0};
    tab[9]  = '{K_DRW, 32'h1000_0000, 32'h5555_AAAA, 4'hF,   0, -1, 2'b00, 4'd0, ID_D, 1'b0};
    tab[10] = '{K_DR,  32'h1000_0008, 32'h0,         4'h0,   0,  0, 2'b00, 4'd0, ID_D, 1'b1};

    repeat (3) step();
    chk("rst_valids", {26'h0, ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY}, 32'd0);
    chk("rst_resp", {27'h0, i_rvalid, d_rvalid, i_done, d_done, err}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", ARADDR | AWADDR | WDATA, 32'h0);
    chk("rst_wstrb", {28'h0, WSTRB}, 32'h0);
    chk("rst_size_burst", {22'h0, ARSIZE, AWSIZE, ARBURST, AWBURST}, {22'h0, 3'd2, 3'd2, 2'b01, 2'b01});
    ARESETn = 1'b1;
    step();

    // Both sides requesting continuously: grants alternate starting with I
    i_req  = 1'b1;
    d_rreq = 1'b1;
    i_addr = 32'h0000_4000;
    d_addr = 32'h2000_0100;
    for (int t = 0; t < 4; t++) begin
      wait_addr(1'b0, cyc, ok);
      chk("alt_seen", {31'h0, ok}, 32'd1);
      if (!ok) break;
      chk("alt_latency", cyc, (t == 0) ? 32'd1 : 32'd2);
      chk("alt_arid", {28'h0, ARID}, (t % 2 == 1) ? 32'd1 : 32'd0);
      chk("alt_araddr", ARADDR, (t % 2 == 1) ? 32'h2000_0100 : 32'h0000_4000);
      ARREADY = 1'b1;
      step();
      ARREADY = 1'b0;
      for (int b = 0; b < 4; b++) begin
        RVALID = 1'b1;
        RDATA  = 32'h1111_0000 + t * 16 + b;
        RLAST  = (b == 3);
        step();
      end
      RVALID = 1'b0;
      RLAST  = 1'b0;
      chk("alt_done", {30'h0, i_done, d_done}, (t % 2 == 1) ? 32'd1 : 32'd2);
    end
    i_req  = 1'b0;
    d_rreq = 1'b0;
    repeat (2) step();

    for (int n = 0; n < 11; n++) begin
      run_txn(tab[n], $sformatf("vec%0d", n));
    end

    // Reset during beat 2 of an I refill
    i_req  = 1'b1;
    i_addr = 32'h0000_8000;
    wait_addr(1'b0, cyc, ok);
    chk("rst_mid_seen", {31'h0, ok}, 32'd1);
    ARREADY = 1'b1;
    step();
    ARREADY = 1'b0;
    adata  = 32'h0000_0001;
    RVALID = 1'b1;
    RDATA  = adata;
    step();
    chk("rst_mid_beat1", {31'h0, i_rvalid}, 32'd1);
    RDATA   = 32'h0000_0002;
    ARESETn = 1'b0;
    step();
    chk("rst_mid_rready", {31'h0, RREADY}, 32'd0);
    chk("rst_mid_outs", {29'h0, i_rvalid, i_done, err}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'h0);
    RVALID  = 1'b0;
    i_req   = 1'b0;
    ARESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_mid_quiet", {29'h0, i_done, d_done, ARVALID}, 32'd0);
    end
    run_txn(tab[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
